// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtraction controller: drives one external full subtractor cell
// LSB-first over WIDTH cycles and collects diff = a - b with the final borrow.
module serial_subtractor_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fs_a,
  output logic             fs_b,
  output logic             fs_bin,
  input  logic             fs_d,
  input  logic             fs_bout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CW   = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
  localparam int unsigned LAST = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             step;
  logic             last_step;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;

  // State register plus registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == DONE);
    end
  end

  // Next-state decode and per-cycle strobes
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    last_step  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(LAST)) begin
          last_step  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign res_next = {fs_d, res_sh[WIDTH-1:1]};

  // Counter, borrow chain and visible results
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      borrow     <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      borrow <= 1'b0;
    end else if (step) begin
      cnt    <= cnt + CW'(1);
      borrow <= fs_bout;
      if (last_step) begin
        diff       <= res_next;
        borrow_out <= fs_bout;
      end
    end
  end

  // Operand and result shifters carry no reset; the cell inputs are gated by state
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh <= a;
      b_sh <= b;
    end else if (step) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      res_sh <= res_next;
    end
  end

  assign fs_a   = (state == RUN) & a_sh[0];
  assign fs_b   = (state == RUN) & b_sh[0];
  assign fs_bin = (state == RUN) & borrow;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl with a behavioural full subtractor cell.
module tb_serial_subtractor_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             fs_a;
  logic             fs_b;
  logic             fs_bin;
  logic             fs_d;
  logic             fs_bout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  // Reference full subtractor cell
  assign fs_d    = fs_a ^ fs_b ^ fs_bin;
  assign fs_bout = (~fs_a & fs_b) | (~(fs_a ^ fs_b) & fs_bin);

  serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .fs_a(fs_a), .fs_b(fs_b), .fs_bin(fs_bin), .fs_d(fs_d), .fs_bout(fs_bout),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'h00;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, done, diff, borrow_out, fs_a, fs_b, fs_bin} !== 13'd0) begin
      failed++;
      $display("FAIL reset: busy=%b done=%b diff=%h bo=%b fs=%b%b%b, required all 0",
               busy, done, diff, borrow_out, fs_a, fs_b, fs_bin);
    end
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, fs_a, fs_b, fs_bin} !== 4'd0) begin
      failed++;
      $display("FAIL idle_fs: busy=%b fs=%b%b%b, required 0", busy, fs_a, fs_b, fs_bin);
    end
  endtask

  // One operation; optional stray start pulse mid-run must be ignored
  task automatic do_op(input string name, input logic [7:0] va, input logic [7:0] vb,
                       input logic [7:0] exp_d, input logic exp_bo, input bit poke);
    int cyc;
    int busy_cnt;
    a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; busy_cnt = 0;
    while (!done && cyc < 20) begin
      if (busy) busy_cnt++;
      if (poke && cyc == 3) begin
        start = 1'b1; a = 8'h77; b = 8'h11;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    tests++;
    if (cyc !== WIDTH) begin
      failed++;
      $display("FAIL %s latency: done after %0d cycles, required %0d", name, cyc, WIDTH);
    end
    tests++;
    if (diff !== exp_d || borrow_out !== exp_bo) begin
      failed++;
      $display("FAIL %s result: diff=%h bo=%b, required diff=%h bo=%b",
               name, diff, borrow_out, exp_d, exp_bo);
    end
    tests++;
    if ({busy, fs_a, fs_b, fs_bin} !== 4'b1000) begin
      failed++;
      $display("FAIL %s done_cycle: busy=%b fs=%b%b%b, required busy=1 fs=000",
               name, busy, fs_a, fs_b, fs_bin);
    end
    if (busy) busy_cnt++;
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || busy_cnt !== WIDTH + 1) begin
      failed++;
      $display("FAIL %s pulse: done=%b busy=%b busy_cycles=%0d, required 0 0 %0d",
               name, done, busy, busy_cnt, WIDTH + 1);
    end
  endtask

  task automatic test_basic();
    do_op("5a_3c", 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
    do_op("00_01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    do_op("ff_ff", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    do_op("80_7f", 8'h80, 8'h7F, 8'h01, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_start();
    do_op("ignore", 8'h10, 8'h05, 8'h0B, 1'b0, 1'b1);
  endtask

  // start held high: one accept every WIDTH+2 cycles, operand changes mid-run ignored
  task automatic test_back_to_back();
    int k;
    a = 8'h10; b = 8'h20; start = 1'b1;
    k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    for (int op = 0; op < 3; op++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
        if (k == 4) begin a = 8'hFF; b = 8'h00; end
        if (k == 8) begin a = 8'h10; b = 8'h20; end
      end while (!done && k < 20);
      tests++;
      if (k !== WIDTH + 2 || diff !== 8'hF0 || borrow_out !== 1'b1) begin
        failed++;
        $display("FAIL b2b%0d: period=%0d diff=%h bo=%b, required %0d F0 1",
                 op, k, diff, borrow_out, WIDTH + 2);
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    a = 8'h5A; b = 8'h3C; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({busy, done, diff, borrow_out, fs_a, fs_b, fs_bin} !== 13'd0) begin
      failed++;
      $display("FAIL mid_reset: busy=%b done=%b diff=%h bo=%b fs=%b%b%b, required all 0",
               busy, done, diff, borrow_out, fs_a, fs_b, fs_bin);
    end
    do_op("after_rst", 8'h03, 8'h01, 8'h02, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
